spi_master_port: RTL and testbench

SPI master that issues single-byte read and write transactions to the lab's SPI memory slave. It sits between on-chip logic, which uses a start/done handshake, and the four SPI pins. Each 16-bit frame is a command byte {addr[6:0], rw} followed by one data byte, sent MSB first. SCLK is generated from the system clock by an integer divider slow enough for the slave's input conditioners.

---
 rtl/spi_pkg.sv | 39 +++
 rtl/spi_master_port_if.sv | 16 +
 rtl/spi_tick_gen.sv | 30 +++
 rtl/spi_master_port.sv | 180 ++++++++++++++++++
 tb/tb_spi_master_port.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the spi_master_port block.
package spi_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned ADDR_BITS  = 7;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned DIV_BITS   = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_e;

  // One SPI frame: command byte {addr, rw} followed by the data byte.
  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic                 rw;
    logic [DATA_BITS-1:0] data;
  } frame_t;

  // Build the outgoing frame; reads send an all-zero data byte.
  function automatic frame_t make_frame(input logic [ADDR_BITS-1:0] addr,
                                        input logic                 rw,
                                        input logic [DATA_BITS-1:0] wdata);
    frame_t f;
    f.addr = addr;
    f.rw   = rw;
    f.data = (rw == RW_WRITE) ? wdata : '0;
    return f;
  endfunction

endpackage

// File: rtl/spi_master_port_if.sv
// Start/done request bus between on-chip logic and the SPI master.
interface spi_master_port_if;
  import spi_pkg::*;

  logic                 start;
  logic                 rw;
  logic [ADDR_BITS-1:0] addr;
  logic [DATA_BITS-1:0] wdata;
  logic                 busy;
  logic                 done;
  logic [DATA_BITS-1:0] rdata;

  modport master (output start, rw, addr, wdata, input busy, done, rdata);
  modport slave  (input start, rw, addr, wdata, output busy, done, rdata);

endinterface

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: CLK_DIV down-counter, reloaded on clear or tick.
module spi_tick_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick_c
);

  localparam logic [DIV_BITS-1:0] RELOAD = DIV_BITS'(CLK_DIV - 1);

  logic [DIV_BITS-1:0] cnt;

  assign tick_c = (cnt == '0);

  // Count down once per cycle; restart the half-period on state entry or tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RELOAD;
    end else if (clear || tick_c) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - DIV_BITS'(1);
    end
  end

endmodule

// File: rtl/spi_master_port.sv
// SPI master for single-byte read/write frames to the lab SPI memory slave.
// Optional feature macro: SPI_MASTER_MISO_SYNC_EN (two-flop MISO synchronizer).
module spi_master_port
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_master_port_if.slave  bus,
  output logic              sclk_pin,
  output logic              cs_pin,
  output logic              mosi_pin,
  input  logic              miso_pin
);

`ifdef SPI_MASTER_MISO_SYNC_EN
  localparam int unsigned MIN_DIV = 3;
`else
  localparam int unsigned MIN_DIV = 2;
`endif

  // Reject divider values the SCLK timing cannot honour.
  if (CLK_DIV < MIN_DIV || CLK_DIV > 255) begin : g_div_check
    $error("spi_master_port: CLK_DIV out of legal range");
  end

  logic miso_s;

`ifdef SPI_MASTER_MISO_SYNC_EN
  logic [1:0] miso_sync;

  // Two-flop synchronizer; the sample point stays put, data is two cycles old.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_sync <= '0;
    end else begin
      miso_sync <= {miso_sync[0], miso_pin};
    end
  end

  assign miso_s = miso_sync[1];
`else
  assign miso_s = miso_pin;
`endif

  state_e               state, state_nxt;
  frame_t               frame, frame_nxt;
  logic                 rw_q, rw_nxt;
  logic [3:0]           bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] rx, rx_nxt;
  logic [DATA_BITS-1:0] rdata_q, rdata_nxt;
  logic                 sclk_q, sclk_nxt;
  logic                 cs_q, cs_nxt;
  logic                 mosi_q, mosi_nxt;
  logic                 busy_q, busy_nxt;
  logic                 done_q, done_nxt;
  logic                 tick_c;
  logic                 tick_clear_c;

  assign tick_clear_c = (state_nxt != state);

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tick_clear_c),
    .tick_c (tick_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      frame   <= '0;
      rw_q    <= RW_WRITE;
      bit_idx <= '0;
      rx      <= '0;
      rdata_q <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      frame   <= frame_nxt;
      rw_q    <= rw_nxt;
      bit_idx <= bit_idx_nxt;
      rx      <= rx_nxt;
      rdata_q <= rdata_nxt;
      sclk_q  <= sclk_nxt;
      cs_q    <= cs_nxt;
      mosi_q  <= mosi_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  // Next-state and next-output logic; every move after IDLE waits for a tick.
  always_comb begin
    state_nxt   = state;
    frame_nxt   = frame;
    rw_nxt      = rw_q;
    bit_idx_nxt = bit_idx;
    rx_nxt      = rx;
    rdata_nxt   = rdata_q;
    sclk_nxt    = sclk_q;
    cs_nxt      = cs_q;
    mosi_nxt    = mosi_q;
    busy_nxt    = busy_q;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          rw_nxt      = bus.rw;
          frame_nxt   = make_frame(bus.addr, bus.rw, bus.wdata);
          mosi_nxt    = frame_nxt[FRAME_BITS-1];
          cs_nxt      = 1'b0;
          busy_nxt    = 1'b1;
          bit_idx_nxt = '0;
          state_nxt   = SETUP;
        end
      end
      SETUP: begin
        if (tick_c) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (tick_c) begin
          if (!sclk_q) begin
            // Rising edge: capture the data byte of a read.
            sclk_nxt = 1'b1;
            if (rw_q == RW_READ && bit_idx >= 4'(CMD_BITS)) begin
              rx_nxt = {rx[DATA_BITS-2:0], miso_s};
            end
          end else begin
            // Falling edge: present the next frame bit.
            sclk_nxt    = 1'b0;
            frame_nxt   = frame_t'({frame[FRAME_BITS-2:0], 1'b0});
            mosi_nxt    = frame_nxt[FRAME_BITS-1];
            bit_idx_nxt = bit_idx + 4'd1;
            if (bit_idx == 4'(FRAME_BITS - 1)) begin
              mosi_nxt  = 1'b0;
              state_nxt = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (tick_c) begin
          cs_nxt    = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (tick_c) begin
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
          if (rw_q == RW_READ) begin
            rdata_nxt = rx;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign sclk_pin  = sclk_q;
  assign cs_pin    = cs_q;
  assign mosi_pin  = mosi_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_spi_master_port.sv
// Self-checking bench for spi_master_port: SPI memory slave model plus a
// memory/rdata reference model feeding a scoreboard checked on every done.
module tb_spi_master_port;

  localparam int DIV     = 4;
  localparam int TXN_LEN = 1 + 35 * DIV;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  rdata;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic sclk_pin, cs_pin, mosi_pin, miso_pin;

  spi_master_port_if bus ();

  spi_master_port #(.CLK_DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .sclk_pin (sclk_pin),
    .cs_pin   (cs_pin),
    .mosi_pin (mosi_pin),
    .miso_pin (miso_pin)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int failures = 0;
  int done_seen = 0;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem [0:127];
  logic [7:0]  ref_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SPI memory slave: command byte then data byte, MISO changes on falling SCLK.
  logic [7:0]  slv_mem [0:127];
  logic [15:0] slv_sh;
  logic [7:0]  slv_rd;
  logic        slv_is_rd;
  int          slv_cnt;
  int          stray_rises;
  int          total_rises;
  logic [15:0] slv_frames[$];

  initial begin : slave_model
    logic last_sclk, last_cs;
    miso_pin = 1'b0;
    slv_sh = '0; slv_rd = '0; slv_is_rd = 1'b0; slv_cnt = 0;
    stray_rises = 0; total_rises = 0;
    last_sclk = 1'b0; last_cs = 1'b1;
    forever begin
      @(sclk_pin or cs_pin);
      if (cs_pin === 1'b0 && last_cs !== 1'b0) begin
        slv_cnt = 0; slv_sh = '0; slv_is_rd = 1'b0; miso_pin = 1'b0;
      end
      if (sclk_pin === 1'b1 && last_sclk !== 1'b1) begin
        total_rises++;
        if (cs_pin !== 1'b0) begin
          stray_rises++;
        end else begin
          slv_sh = {slv_sh[14:0], mosi_pin};
          slv_cnt++;
          if (slv_cnt == 8) begin
            slv_is_rd = slv_sh[0];
            slv_rd    = slv_mem[slv_sh[7:1]];
          end
          if (slv_cnt == 16) begin
            slv_frames.push_back(slv_sh);
            if (!slv_is_rd) slv_mem[slv_sh[15:9]] = slv_sh[7:0];
          end
        end
      end else if (sclk_pin === 1'b0 && last_sclk === 1'b1 && cs_pin === 1'b0) begin
        if (slv_is_rd && slv_cnt >= 8 && slv_cnt < 16) miso_pin = slv_rd[3'(15 - slv_cnt)];
        else miso_pin = 1'b0;
      end
      last_sclk = sclk_pin;
      last_cs   = cs_pin;
    end
  end

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  initial begin : monitor
    exp_t        e;
    logic [15:0] f;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_seen++;
        check("done_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("done_latency", 32'(cyc), 32'(e.done_cyc));
          check("rdata", 32'(bus.rdata), 32'(e.rdata));
          check("busy_in_done", 32'(bus.busy), 32'd0);
          check("cs_in_done", 32'(cs_pin), 32'd1);
          check("sclk_rises", 32'(slv_cnt), 32'd16);
          check("frame_count", 32'(slv_frames.size()), 32'd1);
          if (slv_frames.size() != 0) begin
            f = slv_frames.pop_front();
            check("mosi_frame", 32'(f), 32'(e.frame));
          end
        end
      end
    end
  end

  // Wait for IDLE, then issue one request and record its expected outcome.
  task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] d,
                       input int gap, output int k);
    exp_t e;
    int   guard;
    guard = 0;
    while (bus.busy === 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("idle_wait_timeout", 32'(guard >= 1000), 32'd0);
    repeat (gap) @(negedge clk);
    bus.start = 1'b1; bus.rw = r; bus.addr = a; bus.wdata = d;
    if (r) begin
      e.frame   = {a, 1'b1, 8'h00};
      e.rdata   = ref_mem[a];
      ref_rdata = ref_mem[a];
    end else begin
      e.frame    = {a, 1'b0, d};
      e.rdata    = ref_rdata;
      ref_mem[a] = d;
    end
    e.done_cyc = cyc + TXN_LEN;
    k = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.rw    = 1'($urandom);
    bus.addr  = 7'($urandom);
    bus.wdata = 8'($urandom);
  endtask

  // Pulse start mid-transaction; it must be dropped, not queued.
  task automatic poke_busy();
    repeat ($urandom_range(3, 120)) @(negedge clk);
    check("busy_during_poke", 32'(bus.busy), 32'd1);
    bus.start = 1'b1;
    bus.rw    = 1'($urandom);
    bus.addr  = 7'($urandom);
    bus.wdata = 8'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int k, guard, rises0, done0;
    logic       r;
    logic [6:0] a;
    logic [7:0] d;

    for (int i = 0; i < 128; i++) begin
      slv_mem[i] = 8'($urandom);
      ref_mem[i] = slv_mem[i];
    end
    ref_rdata = 8'h00;
    bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0;
    rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(cs_pin), 32'd1);
    check("rst_sclk", 32'(sclk_pin), 32'd0);
    check("rst_mosi", 32'(mosi_pin), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    rst_n = 1'b1;
    rises0 = total_rises;
    repeat (200) @(negedge clk);
    check("idle_sclk_edges", 32'(total_rises - rises0), 32'd0);
    check("idle_cs", 32'(cs_pin), 32'd1);

    // Write 0x05 <= 0xA5 with an ignored start pulse, then back-to-back read.
    issue(1'b0, 7'h05, 8'hA5, 0, k);
    poke_busy();
    issue(1'b1, 7'h05, 8'h00, 0, k);
    // Write 0x2A <= 0x3C and read it back.
    issue(1'b0, 7'h2A, 8'h3C, 0, k);
    issue(1'b1, 7'h2A, 8'h00, 0, k);

    // Reset in the middle of bit 9 of a read.
    issue(1'b1, 7'h05, 8'h00, 2, k);
    while (cyc < k + 1 + DIV + 9 * 2 * DIV + DIV / 2) @(negedge clk);
    check("cs_low_before_reset", 32'(cs_pin), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_cs", 32'(cs_pin), 32'd1);
    check("abort_sclk", 32'(sclk_pin), 32'd0);
    check("abort_rdata", 32'(bus.rdata), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    void'(exp_q.pop_back());
    ref_rdata = 8'h00;
    done0 = done_seen;
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("abort_no_done", 32'(done_seen - done0), 32'd0);
    issue(1'b1, 7'h05, 8'h00, 0, k);

    // Randomized traffic over a small address window so reads hit writes.
    for (int i = 0; i < 24; i++) begin
      r = 1'($urandom_range(0, 1));
      a = 7'($urandom_range(0, 7));
      d = 8'($urandom);
      issue(r, a, d, int'($urandom_range(0, 3)), k);
      if ($urandom_range(0, 3) == 0) poke_busy();
    end

    // Drain the scoreboard.
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (20) @(negedge clk);
    check("stray_sclk_edges", 32'(stray_rises), 32'd0);
    check("leftover_frames", 32'(slv_frames.size()), 32'd0);
    check("final_idle", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
